// File: rtl/multibyte_cla_sequencer.sv
// ============================================================================
// Module  : multibyte_cla_sequencer
// Purpose : Feeds wide operands byte-serially (LSB first) to an external 8-bit
//           CLA, chaining its carry, and returns the assembled wide result.
//           Optional subtract/overflow support under macro ADD_SUB_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multibyte_cla_sequencer #(
  parameter int NBYTES = 4,
  localparam int W     = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
`ifdef ADD_SUB_EN
  input  logic         in_sub,
  output logic         out_ovf,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic [7:0]   add_a,
  output logic [7:0]   add_b,
  output logic         add_cin,
  input  logic [7:0]   add_sum,
  input  logic         add_cout
);

  localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [W-1:0]       a_q,     a_d;
  logic [W-1:0]       b_q,     b_d;
  logic [W-1:0]       sum_q,   sum_d;
  logic               carry_q, carry_d;
  logic               cout_q,  cout_d;
`ifdef ADD_SUB_EN
  logic               sub_q,   sub_d;
  logic               ovf_q,   ovf_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef ADD_SUB_EN
      sub_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef ADD_SUB_EN
      sub_q   <= sub_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
`ifdef ADD_SUB_EN
    sub_d   = sub_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cnt_d   = '0;
          carry_d = in_cin;
`ifdef ADD_SUB_EN
          // Subtraction is A + ~B + 1, so the initial carry is forced high.
          sub_d   = in_sub;
          if (in_sub) carry_d = 1'b1;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        add_a   = a_q[7:0];
        add_b   = b_q[7:0];
`ifdef ADD_SUB_EN
        if (sub_q) add_b = ~b_q[7:0];
`endif
        add_cin = carry_q;
        sum_d[{cnt_q, 3'b000} +: 8] = add_sum;
        carry_d = add_cout;
        a_d     = a_q >> 8;
        b_d     = b_q >> 8;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == C_LAST) begin
          cout_d  = add_cout;
`ifdef ADD_SUB_EN
          ovf_d   = (add_a[7] ^ add_b[7] ^ add_sum[7]) ^ add_cout;
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
`ifdef ADD_SUB_EN
  assign out_ovf   = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multibyte_cla_sequencer.sv
// ============================================================================
// Module  : tb_multibyte_cla_sequencer
// Purpose : Directed-vector and random checks of multibyte_cla_sequencer with
//           NBYTES=4 and NBYTES=1 instances driving behavioural 8-bit adders.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multibyte_cla_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // NBYTES=4 instance
  logic        in_valid4 = 1'b0, in_cin4 = 1'b0, out_ready4 = 1'b0, in_sub4 = 1'b0;
  logic [31:0] in_a4 = '0, in_b4 = '0;
  logic        in_ready4, out_valid4, out_cout4, add_cin4, add_cout4;
  logic [31:0] out_sum4;
  logic [7:0]  add_a4, add_b4, add_sum4;
`ifdef ADD_SUB_EN
  logic        out_ovf4;
`endif
  assign {add_cout4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + {8'd0, add_cin4};

  multibyte_cla_sequencer #(.NBYTES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
`ifdef ADD_SUB_EN
    .in_sub(in_sub4), .out_ovf(out_ovf4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_sum(out_sum4), .out_cout(out_cout4),
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
    .add_sum(add_sum4), .add_cout(add_cout4)
  );

  // NBYTES=1 instance
  logic       in_valid1 = 1'b0, in_cin1 = 1'b0, out_ready1 = 1'b0;
  logic [7:0] in_a1 = '0, in_b1 = '0;
  logic       in_ready1, out_valid1, out_cout1, add_cin1, add_cout1;
  logic [7:0] out_sum1, add_a1, add_b1, add_sum1;
`ifdef ADD_SUB_EN
  logic       in_sub1 = 1'b0;
  logic       out_ovf1;
`endif
  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {8'd0, add_cin1};

  multibyte_cla_sequencer #(.NBYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
`ifdef ADD_SUB_EN
    .in_sub(in_sub1), .out_ovf(out_ovf1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_cout(out_cout1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction on the 4-byte instance; holds out_ready low for
  // 'hold' cycles once the result is valid, checking stability meanwhile.
  task automatic op4(input logic [31:0] a, input logic [31:0] b, input logic cin,
                     input logic sub, input int hold,
                     output logic [31:0] s, output logic co, output logic ov,
                     output int lat);
    check("in_ready_idle", in_ready4, 1);
    in_valid4 = 1'b1; in_a4 = a; in_b4 = b; in_cin4 = cin; in_sub4 = sub;
    @(posedge clk); #1;
    in_valid4 = 1'b1; in_a4 = 32'hFFFF_FFFF; in_b4 = 32'hFFFF_FFFF; in_cin4 = 1'b1;
    check("in_ready_busy", in_ready4, 0);
    lat = 0;
    while (!out_valid4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid4 = 1'b0;
    if (!out_valid4) check("out_valid_timeout", 0, 1);
    s  = out_sum4;
    co = out_cout4;
    ov = 1'b0;
`ifdef ADD_SUB_EN
    ov = out_ovf4;
`endif
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid4, 1);
      check("hold_sum", out_sum4, s);
      check("hold_cout", out_cout4, co);
      check("hold_in_ready", in_ready4, 0);
    end
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    check("out_valid_drop", out_valid4, 0);
    check("in_ready_after", in_ready4, 1);
  endtask

  task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     output logic [7:0] s, output logic co, output int lat);
    in_valid1 = 1'b1; in_a1 = a; in_b1 = b; in_cin1 = cin;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid1) check("out_valid1_timeout", 0, 1);
    s  = out_sum1;
    co = out_cout1;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1 out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check("in_ready1_after", in_ready1, 1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] s;
    logic        co, ov;
    int          lat;
    logic [7:0]  s1;
    logic        co1;
    logic [32:0] ref33;
    logic [8:0]  ref9;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h8000_0001, 32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1};
    vecs[3] = '{32'h0000_0019, 32'h0000_0031, 1'b0, 32'h0000_004A, 1'b0};
    vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};
    vecs[8] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};
    vecs[9] = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 32'hDEAD_BEF0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready4, 1);
    check("rst_out_valid", out_valid4, 0);
    check("rst_out_sum", out_sum4, 0);
    check("rst_out_cout", out_cout4, 0);
    check("rst_add_a", {add_a4, add_b4, add_cin4}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    foreach (vecs[i]) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 0, s, co, ov, lat);
      check($sformatf("vec%0d_sum", i), s, vecs[i].exp_sum);
      check($sformatf("vec%0d_cout", i), co, vecs[i].exp_cout);
      check($sformatf("vec%0d_latency", i), lat, 4);
    end

    // Backpressure: result held for 3 cycles
    op4(32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0, 3, s, co, ov, lat);
    check("hold_final_sum", s, 32'h0000_0002);
    check("hold_final_cout", co, 1);

    // Reset during the second RUN cycle
    in_valid4 = 1'b1; in_a4 = 32'h0102_0304; in_b4 = 32'h0506_0708; in_cin4 = 1'b0;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", in_ready4, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid4, 0);
    check("mid_rst_out_sum", out_sum4, 0);
    check("mid_rst_out_cout", out_cout4, 0);
    check("mid_rst_in_ready", in_ready4, 1);
    check("mid_rst_add", {add_a4, add_b4, add_cin4}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    op4(32'h0000_0019, 32'h0000_0031, 1'b0, 1'b0, 0, s, co, ov, lat);
    check("post_rst_sum", s, 32'h0000_004A);
    check("post_rst_cout", co, 0);

`ifdef ADD_SUB_EN
    op4(32'd5, 32'd7, 1'b0, 1'b1, 0, s, co, ov, lat);
    check("sub1_sum", s, 32'hFFFF_FFFE);
    check("sub1_cout", co, 0);
    check("sub1_ovf", ov, 0);
    op4(32'h8000_0000, 32'd1, 1'b0, 1'b1, 0, s, co, ov, lat);
    check("sub2_sum", s, 32'h7FFF_FFFF);
    check("sub2_cout", co, 1);
    check("sub2_ovf", ov, 1);
`endif

    // Random 4-byte operations
    for (int n = 0; n < 200; n++) begin
      logic [31:0] ra, rb, es;
      logic        rc, rs, eov;
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1)); rs = 1'b0;
`ifdef ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      op4(ra, rb, rc, rs, $urandom_range(0, 2), s, co, ov, lat);
      if (rs) ref33 = {1'b0, ra} + {1'b0, ~rb} + 33'd1;
      else    ref33 = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      es = ref33[31:0];
      check("rand4_result", {co, s}, ref33);
`ifdef ADD_SUB_EN
      eov = rs ? ((ra[31] != rb[31]) && (es[31] != ra[31]))
               : ((ra[31] == rb[31]) && (es[31] != ra[31]));
      check("rand4_ovf", ov, eov);
`else
      eov = 1'b0;
      if (eov) check("rand4_ovf", ov, eov);
`endif
    end

    // Random 1-byte operations
    for (int n = 0; n < 200; n++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
      op1(ra, rb, rc, s1, co1, lat);
      ref9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      check("rand1_result", {co1, s1}, ref9);
      check("rand1_latency", lat, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
